// File: rtl/imem_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream, instruction-memory write and status bundle for imem_loader
// Revision : 1.0
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              restart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output in_valid, in_data, restart,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err, words_loaded
    );

    modport slave (
        input  in_valid, in_data, restart,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot loader: length-prefixed, XOR-checked byte image into instruction memory
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    imem_loader_if.slave     bus
);
    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam logic [2:0] c_S_LEN0 = 3'd0;
    localparam logic [2:0] c_S_LEN1 = 3'd1;
    localparam logic [2:0] c_S_DATA = 3'd2;
    localparam logic [2:0] c_S_CSUM = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;
    localparam logic [2:0] c_S_ERR  = 3'd5;

    localparam logic [31:0] c_DEPTH = 32'(1) << ADDR_W;

    logic [2:0]  r_state;
    logic [7:0]  r_len_lo;
    cnt_t        r_len;
    logic [7:0]  r_xor;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_shift;
    cnt_t        r_words_loaded;
    logic        r_mem_we;
    addr_t       r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_active;
    logic        w_acc;
    logic [15:0] w_len16;
    logic        w_oversize;
    logic        w_last_word;

    assign w_active    = (r_state == c_S_LEN0) || (r_state == c_S_LEN1) ||
                         (r_state == c_S_DATA) || (r_state == c_S_CSUM);
    assign w_acc       = bus.in_valid && bus.in_ready;
    assign w_len16     = {bus.in_data, r_len_lo};
    assign w_oversize  = {16'd0, w_len16} > c_DEPTH;
    assign w_last_word = (r_words_loaded + cnt_t'(1)) == r_len;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= c_S_LEN0;
            r_len_lo       <= '0;
            r_len          <= '0;
            r_xor          <= '0;
            r_byte_idx     <= '0;
            r_shift        <= '0;
            r_words_loaded <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_S_LEN0: begin
                    if (w_acc) begin
                        r_len_lo <= bus.in_data;
                        r_xor    <= r_xor ^ bus.in_data;
                        r_state  <= c_S_LEN1;
                    end
                end
                c_S_LEN1: begin
                    if (w_acc) begin
                        r_xor <= r_xor ^ bus.in_data;
                        r_len <= cnt_t'(w_len16);
                        if (w_oversize)
                            r_state <= c_S_ERR;
                        else if (w_len16 == 16'd0)
                            r_state <= c_S_CSUM;
                        else
                            r_state <= c_S_DATA;
                    end
                end
                c_S_DATA: begin
                    if (w_acc) begin
                        r_xor      <= r_xor ^ bus.in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            // Word index is the pre-increment word count.
                            r_mem_we       <= 1'b1;
                            r_mem_addr     <= addr_t'(BASE_ADDR) + r_words_loaded[ADDR_W-1:0];
                            r_mem_wdata    <= {bus.in_data, r_shift};
                            r_words_loaded <= r_words_loaded + cnt_t'(1);
                            if (w_last_word)
                                r_state <= c_S_CSUM;
                        end else begin
                            r_shift <= {bus.in_data, r_shift[23:8]};
                        end
                    end
                end
                c_S_CSUM: begin
                    if (w_acc)
                        r_state <= (bus.in_data == r_xor) ? c_S_DONE : c_S_ERR;
                end
                c_S_DONE, c_S_ERR: begin
                    if (bus.restart) begin
                        r_state        <= c_S_LEN0;
                        r_xor          <= '0;
                        r_byte_idx     <= '0;
                        r_shift        <= '0;
                        r_words_loaded <= '0;
                        r_len          <= '0;
                        r_len_lo       <= '0;
                    end
                end
                default: r_state <= c_S_LEN0;
            endcase
        end
    end

    assign bus.in_ready     = reset && w_active;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.done         = (r_state == c_S_DONE);
    assign bus.err          = (r_state == c_S_ERR);
    assign bus.cpu_run      = (r_state == c_S_DONE);
    assign bus.words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Scoreboard bench driving two loaders (BASE_ADDR 0 and 4) in lockstep
// Revision : 1.0
// ============================================================================
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       r_in_valid;
    logic [7:0] r_in_data;
    logic       r_restart;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(8)) if0 ();
    imem_loader_if #(.ADDR_W(8)) if1 ();

    assign if0.in_valid = r_in_valid;
    assign if0.in_data  = r_in_data;
    assign if0.restart  = r_restart;
    assign if1.in_valid = r_in_valid;
    assign if1.in_data  = r_in_data;
    assign if1.restart  = r_restart;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (.clk(clk), .reset(rst_n), .bus(if0.slave));
    imem_loader #(.ADDR_W(8), .BASE_ADDR(4)) dut1 (.clk(clk), .reset(rst_n), .bus(if1.slave));

    int checks   = 0;
    int failures = 0;

    logic [39:0] q0[$];
    logic [39:0] q1[$];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected writes: same word on both loaders, dut1 offset by its base of 4.
    task automatic exp_write(input logic [7:0] idx, input logic [31:0] data);
        q0.push_back({idx, data});
        q1.push_back({idx + 8'd4, data});
    endtask

    always @(negedge clk) begin
        if (if0.mem_we === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut0 unexpected write: addr %h data %h", if0.mem_addr, if0.mem_wdata);
            end else
                chk("dut0 write", {if0.mem_addr, if0.mem_wdata}, q0.pop_front());
        end
        if (if1.mem_we === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut1 unexpected write: addr %h data %h", if1.mem_addr, if1.mem_wdata);
            end else
                chk("dut1 write", {if1.mem_addr, if1.mem_wdata}, q1.pop_front());
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        bit acc;
        acc = 1'b0;
        r_in_valid = 1'b1;
        r_in_data  = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (if0.in_ready === 1'b1) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send timeout: in_ready low for byte %h", b);
        end
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        r_in_data  = 8'hxx;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_restart();
        r_restart = 1'b1;
        @(posedge clk); #1;
        r_restart = 1'b0;
    endtask

    task automatic send_single(input logic [7:0] csum);
        send(8'h01, 0); send(8'h00, 0);
        send(8'h44, 0); send(8'h33, 0); send(8'h22, 0); send(8'h11, 0);
        send(csum, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; r_in_valid = 1'b0; r_in_data = 8'h00; r_restart = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready",     {39'd0, if0.in_ready}, 40'd0);
        chk("reset mem_we",       {39'd0, if0.mem_we},   40'd0);
        chk("reset mem_addr",     {32'd0, if0.mem_addr}, 40'd0);
        chk("reset mem_wdata",    {8'd0, if0.mem_wdata}, 40'd0);
        chk("reset status",       {37'd0, if0.cpu_run, if0.done, if0.err}, 40'd0);
        chk("reset words_loaded", {31'd0, if0.words_loaded}, 40'd0);
        chk("reset dut1 mem_addr", {32'd0, if1.mem_addr}, 40'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle in_ready", {39'd0, if0.in_ready}, 40'd1);
        @(posedge clk); #1;

        // Single word, good checksum
        exp_write(8'd0, 32'h11223344);
        send_single(8'h45);
        @(negedge clk);
        chk("single status run/done/err/rdy",
            {36'd0, if0.cpu_run, if0.done, if0.err, if0.in_ready}, 40'b1100);
        chk("single words_loaded", {31'd0, if0.words_loaded}, 40'd1);
        chk("single dut1 done",    {39'd0, if1.done}, 40'd1);
        @(posedge clk); #1;

        pulse_restart();
        @(negedge clk);
        chk("restart run/done/rdy", {37'd0, if0.cpu_run, if0.done, if0.in_ready}, 40'b001);
        chk("restart words_loaded", {31'd0, if0.words_loaded}, 40'd0);
        @(posedge clk); #1;

        // Two words with one-cycle in_valid gaps
        exp_write(8'd0, 32'h00500093);
        exp_write(8'd1, 32'hFFDFF06F);
        send(8'h02, 1); send(8'h00, 1);
        send(8'h93, 1); send(8'h00, 1); send(8'h50, 1); send(8'h00, 1);
        send(8'h6F, 1); send(8'hF0, 1); send(8'hDF, 1); send(8'hFF, 1);
        send(8'h7E, 0);
        @(negedge clk);
        chk("two-word done/err", {38'd0, if0.done, if0.err}, 40'b10);
        chk("two-word words_loaded", {31'd0, if0.words_loaded}, 40'd2);
        @(posedge clk); #1;
        pulse_restart();

        // Bad checksum: word still written, image rejected
        exp_write(8'd0, 32'h11223344);
        send_single(8'h46);
        @(negedge clk);
        chk("badcsum run/done/err/rdy",
            {36'd0, if0.cpu_run, if0.done, if0.err, if0.in_ready}, 40'b0010);
        chk("badcsum words_loaded", {31'd0, if0.words_loaded}, 40'd1);
        @(posedge clk); #1;
        pulse_restart();

        // Oversize length 257
        send(8'h01, 0); send(8'h01, 0);
        @(negedge clk);
        chk("oversize err/rdy/done", {37'd0, if0.err, if0.in_ready, if0.done}, 40'b100);
        @(posedge clk); #1;
        pulse_restart();

        // Length 256 is legal; restart mid-stream must be ignored
        send(8'h00, 0); send(8'h01, 0);
        @(negedge clk);
        chk("len256 rdy/err", {38'd0, if0.in_ready, if0.err}, 40'b10);
        @(posedge clk); #1;
        pulse_restart();
        exp_write(8'd0, 32'h11223344);
        send(8'h44, 0); send(8'h33, 0); send(8'h22, 0); send(8'h11, 0);
        @(negedge clk);
        chk("len256 words_loaded", {31'd0, if0.words_loaded}, 40'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Zero length
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        @(negedge clk);
        chk("zero run/done/err", {37'd0, if0.cpu_run, if0.done, if0.err}, 40'b110);
        chk("zero words_loaded", {31'd0, if0.words_loaded}, 40'd0);
        @(posedge clk); #1;
        pulse_restart();

        // Reset after the second payload byte, then a clean load
        send(8'h01, 0); send(8'h00, 0); send(8'h44, 0); send(8'h33, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset-low in_ready", {39'd0, if0.in_ready}, 40'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after reset rdy/words", {30'd0, if0.in_ready, if0.words_loaded}, {30'd0, 1'b1, 9'd0});
        @(posedge clk); #1;
        exp_write(8'd0, 32'h11223344);
        send_single(8'h45);
        @(negedge clk);
        chk("reload done/run", {38'd0, if0.done, if0.cpu_run}, 40'b11);
        chk("reload dut1 done", {39'd0, if1.done}, 40'd1);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("dut0 pending writes", 40'(q0.size()), 40'd0);
        chk("dut1 pending writes", 40'(q1.size()), 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the pipelined processor's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into consecutive instruction-memory word addresses. It validates the image with a length header and an XOR checksum. It holds the processor in reset until a valid image is loaded, then releases it.

## Interface

Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words.
- BASE_ADDR, 0, first word address written.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-low reset.
- in_valid, input, 1, byte-stream valid.
- in_data, input, 8, byte-stream data.
- in_ready, output, 1, loader can accept a byte.
- restart, input, 1, single-cycle pulse; starts a new load from DONE or ERR.
- mem_we, output, 1, instruction-memory write strobe, one cycle per word.
- mem_addr, output, ADDR_W, word address for the write.
- mem_wdata, output, 32, word written.
- cpu_run, output, 1, processor reset release (drive the processor's `reset`); high only in DONE.
- done, output, 1, image loaded and verified.
- err, output, 1, image rejected.
- words_loaded, output, ADDR_W+1, count of words written in the current load.

## Operation

- **Byte acceptance:** a byte is accepted on any edge where in_valid && in_ready. in_data is ignored otherwise.
- **Stream format:** LEN_LO, LEN_HI (16-bit word count N), then N×4 payload bytes (least-significant byte first per word), then CSUM. CSUM = XOR of every preceding byte, including both length bytes.
- **States:**
  - LEN0: accept LEN_LO → LEN1.
  - LEN1: accept LEN_HI. If N > 2^ADDR_W → ERR. Else if N == 0 → CSUM. Else → DATA.
  - DATA: shift bytes into the word assembler. On the 4th byte of a word, register the word. After the N-th word → CSUM.
  - CSUM: accept one byte. If it matches the running XOR → DONE, else → ERR.
  - DONE / ERR: terminal. restart → LEN0, clearing the running XOR, byte index, word index, words_loaded, done and err.
- **in_ready:** 1 in LEN0, LEN1, DATA and CSUM. 0 in DONE, ERR, and whenever reset is low.
- **Writes:** mem_we pulses for exactly one cycle per word. mem_addr = BASE_ADDR + word index, truncated to ADDR_W bits. Word index starts at 0. mem_wdata = {b3,b2,b1,b0}. words_loaded increments together with mem_we.
- **Outputs:** done = (state == DONE); err = (state == ERR); cpu_run = done. Words already written before an ERR remain in memory, but cpu_run stays 0.
- **restart outside DONE/ERR** is ignored.
- **Reset:** reset low at any time, including mid-word or mid-stream, → LEN0 on the next edge. All counters, XOR and the partial word are cleared. Any pending write is dropped.
- **Reset values:** in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, done=0, err=0, words_loaded=0.

## Timing

- mem_we, mem_addr and mem_wdata are registered. They are valid in the cycle immediately after the edge that accepted the 4th byte of a word.
- Back-to-back bytes are accepted one per cycle with no bubbles. in_valid gaps of any length are tolerated.
- done, err and cpu_run assert in the cycle after the CSUM byte is accepted.
- err asserts in the cycle after LEN_HI is accepted when an oversize length is detected.
- in_ready drops in the same cycle done or err rises.
- restart in DONE: cpu_run and done fall in the next cycle, and in_ready rises in that same cycle.
- Minimum load time for N words: 4N+3 accepted bytes. DONE is reached one cycle after the last acceptance.

## Test plan

- **Single word:** reset low 2 cycles, then stream 01 00 44 33 22 11 45 at one byte per cycle. Expect mem_we=1 for one cycle with mem_addr=0x00 and mem_wdata=0x11223344. Next cycle after CSUM: done=1, cpu_run=1, err=0, in_ready=0, words_loaded=1.
- **Back-pressure / gaps:** N=2, words 0x00500093 and 0xFFDFF06F, with in_valid toggling every other cycle. Expect writes at addr 0 and addr 1 with those exact words, done=1, and no extra mem_we pulses.
- **Bad checksum:** the single-word stream with CSUM=0x46. Expect the word still written at addr 0, then err=1, done=0, cpu_run=0, in_ready=0.
- **Oversize length (ADDR_W=8):** stream 01 01 (N=257). Expect err=1 the cycle after the second byte, no mem_we ever, and in_ready=0.
- **Zero length:** stream 00 00 00. Expect done=1, cpu_run=1, words_loaded=0, no mem_we.
- **Reset mid-load and restart:** reset low after the 2nd payload byte, then the full single-word stream. Expect exactly one write of 0x11223344 at addr 0 and done=1. Then pulse restart: expect cpu_run=0 and in_ready=1 the next cycle. Then the single-word stream with BASE_ADDR=4 yields mem_addr=4.
